// File: rtl/morse_char_transmitter.sv
// morse_char_transmitter
//   Converts letter codes into a keyed Morse line at a programmable unit
//   rate. Dot = 1 unit mark, dash = 3 units mark, 1 unit gap between the
//   elements of a letter, 3 units after a letter, and 4 more units for a
//   word space.
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   char_in     0-25 = A-Z, 26 = word space, 27-31 = invalid
//   char_valid  char_in valid this cycle
//   char_ready  character can be accepted this cycle (combinational)
//   serial_out  keyed Morse line, 1 = mark (registered)
//   busy        transmitter not idle (registered)
//   err_invalid one-cycle pulse after an invalid code is accepted
module morse_char_transmitter #(
    parameter int unsigned UNIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       serial_out,
    output logic       busy,
    output logic       err_invalid
);

    localparam int unsigned CNT_W = $clog2(UNIT_CYCLES * 7 + 1);

    // Reload values: counter runs from N-1 down to 0 for an N-cycle state.
    localparam logic [CNT_W-1:0] DOT_CNT  = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_CNT = CNT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LGAP_CNT = CNT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WGAP_CNT = CNT_W'(4 * UNIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, MARK, GAP, LGAP, WGAP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       pat_q, pat_d;    // remaining elements, MSB next, 1 = dash
    logic [1:0]       left_q, left_d;  // elements still to send after current
    logic             serial_q, serial_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             accept;
    logic [5:0]       rom_word;

    // Returns {element count - 1, left-aligned element pattern}.
    function automatic logic [5:0] rom(input logic [4:0] c);
        case (c)
            5'd0:    rom = {2'd1, 4'b0100}; // A .-
            5'd1:    rom = {2'd3, 4'b1000}; // B -...
            5'd2:    rom = {2'd3, 4'b1010}; // C -.-.
            5'd3:    rom = {2'd2, 4'b1000}; // D -..
            5'd4:    rom = {2'd0, 4'b0000}; // E .
            5'd5:    rom = {2'd3, 4'b0010}; // F ..-.
            5'd6:    rom = {2'd2, 4'b1100}; // G --.
            5'd7:    rom = {2'd3, 4'b0000}; // H ....
            5'd8:    rom = {2'd1, 4'b0000}; // I ..
            5'd9:    rom = {2'd3, 4'b0111}; // J .---
            5'd10:   rom = {2'd2, 4'b1010}; // K -.-
            5'd11:   rom = {2'd3, 4'b0100}; // L .-..
            5'd12:   rom = {2'd1, 4'b1100}; // M --
            5'd13:   rom = {2'd1, 4'b1000}; // N -.
            5'd14:   rom = {2'd2, 4'b1110}; // O ---
            5'd15:   rom = {2'd3, 4'b0110}; // P .--.
            5'd16:   rom = {2'd3, 4'b1101}; // Q --.-
            5'd17:   rom = {2'd2, 4'b0100}; // R .-.
            5'd18:   rom = {2'd2, 4'b0000}; // S ...
            5'd19:   rom = {2'd0, 4'b1000}; // T -
            5'd20:   rom = {2'd2, 4'b0010}; // U ..-
            5'd21:   rom = {2'd3, 4'b0001}; // V ...-
            5'd22:   rom = {2'd2, 4'b0110}; // W .--
            5'd23:   rom = {2'd3, 4'b1001}; // X -..-
            5'd24:   rom = {2'd3, 4'b1011}; // Y -.--
            5'd25:   rom = {2'd3, 4'b1100}; // Z --..
            default: rom = '0;
        endcase
    endfunction

    // Ready in IDLE and in the last cycle of a trailing gap, so back-to-back
    // characters follow with no extra idle cycle.
    assign char_ready = (state_q == IDLE) ||
                        (((state_q == LGAP) || (state_q == WGAP)) && (cnt_q == '0));
    assign accept     = char_valid && char_ready;
    assign rom_word   = rom(char_in);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        left_d  = left_q;
        err_d   = 1'b0;
        if (accept) begin
            if (char_in < 5'd26) begin
                state_d = MARK;
                cnt_d   = rom_word[3] ? DASH_CNT : DOT_CNT;
                pat_d   = {rom_word[2:0], 1'b0};
                left_d  = rom_word[5:4];
            end else if (char_in == 5'd26) begin
                state_d = WGAP;
                cnt_d   = WGAP_CNT;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
                err_d   = 1'b1;
            end
        end else begin
            case (state_q)
                MARK: begin
                    if (cnt_q == '0) begin
                        state_d = (left_q != 2'd0) ? GAP : LGAP;
                        cnt_d   = (left_q != 2'd0) ? GAP_CNT : LGAP_CNT;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_d = MARK;
                        cnt_d   = pat_q[3] ? DASH_CNT : DOT_CNT;
                        pat_d   = {pat_q[2:0], 1'b0};
                        left_d  = left_q - 2'd1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                LGAP, WGAP: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        serial_d = (state_d == MARK);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pat_q    <= '0;
            left_q   <= '0;
            serial_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pat_q    <= pat_d;
            left_q   <= left_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign serial_out  = serial_q;
    assign busy        = busy_q;
    assign err_invalid = err_q;

endmodule

// File: tb/tb_morse_char_transmitter.sv
module tb_morse_char_transmitter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] ch1 = '0;
    logic       v1  = 1'b0;
    logic       rdy1, ser1, busy1, err1;
    logic [4:0] ch4 = '0;
    logic       v4  = 1'b0;
    logic       rdy4, ser4, busy4, err4;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    morse_char_transmitter #(.UNIT_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .char_in(ch1), .char_valid(v1),
        .char_ready(rdy1), .serial_out(ser1), .busy(busy1), .err_invalid(err1)
    );

    morse_char_transmitter #(.UNIT_CYCLES(4)) u4 (
        .clk(clk), .rst(rst), .char_in(ch4), .char_valid(v4),
        .char_ready(rdy4), .serial_out(ser4), .busy(busy4), .err_invalid(err4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Single-cycle handshake on the UNIT_CYCLES=1 instance.
    task automatic send1(input logic [4:0] c);
        @(negedge clk);
        chk("send1_ready", rdy1, 1'b1);
        ch1 = c;
        v1  = 1'b1;
        @(posedge clk);
        #1 v1 = 1'b0;
    endtask

    // Check an 8- or 10-cycle serial pattern (MSB first) with busy held high.
    task automatic expect_seq(input string tag, input logic [15:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_ser"}, ser1, pat[n-1-i]);
            chk({tag, "_busy"}, busy1, 1'b1);
        end
        @(negedge clk);
        chk({tag, "_idle"}, busy1, 1'b0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_ser", ser1, 1'b0);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_err", err1, 1'b0);
        chk("rst_ready", rdy1, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // E: 1,0,0,0 with ready only in the last gap cycle
        send1(5'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("E_ser", ser1, (i == 0) ? 1'b1 : 1'b0);
            chk("E_busy", busy1, 1'b1);
            chk("E_ready", rdy1, (i == 3) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        chk("E_idle", busy1, 1'b0);

        // A: .-
        send1(5'd0);
        expect_seq("A", 16'b1011_1000, 8);

        // E then T with valid held high: no idle cycle between letters
        @(negedge clk);
        ch1 = 5'd4;
        v1  = 1'b1;
        @(posedge clk);
        #1 ch1 = 5'd19;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("ET_ser", ser1, (i == 0 || i == 4 || i == 5 || i == 6) ? 1'b1 : 1'b0);
            chk("ET_busy", busy1, 1'b1);
            if (i == 3) begin
                @(posedge clk);
                #1 v1 = 1'b0;
            end
        end
        @(negedge clk);
        chk("ET_idle", busy1, 1'b0);

        // Invalid code 29
        send1(5'd29);
        @(negedge clk);
        chk("inv_err", err1, 1'b1);
        chk("inv_busy", busy1, 1'b0);
        chk("inv_ser", ser1, 1'b0);
        @(negedge clk);
        chk("inv_err_clr", err1, 1'b0);
        chk("inv_ser2", ser1, 1'b0);

        // UNIT_CYCLES=4: T then word space
        @(negedge clk);
        chk("u4_ready", rdy4, 1'b1);
        ch4 = 5'd19;
        v4  = 1'b1;
        @(posedge clk);
        #1 ch4 = 5'd26;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("u4_ser", ser4, (i < 12) ? 1'b1 : 1'b0);
            chk("u4_busy", busy4, 1'b1);
            if (i == 23) begin
                @(posedge clk);
                #1 v4 = 1'b0;
            end
        end
        @(negedge clk);
        chk("u4_idle", busy4, 1'b0);
        chk("u4_err", err4, 1'b0);

        // Reset during the 2nd high cycle of a dash
        send1(5'd19);
        @(negedge clk);
        chk("rdash_ser1", ser1, 1'b1);
        @(negedge clk);
        chk("rdash_ser2", ser1, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("rdash_async", ser1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rdash_busy", busy1, 1'b0);
        chk("rdash_ready", rdy1, 1'b1);
        send1(5'd18);
        expect_seq("S", 16'b1010_1000, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
